// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared constants and types for the Ethernet FCS inserter.
//   CRC_POLY        : Ethernet CRC-32 generator polynomial (normal form)
//   CRC_INIT        : CRC register value at the start of every frame
//   MIN_FRAME_BYTES : minimum payload length before FCS (short frames are padded)
//   FCS_BYTES       : number of FCS bytes appended to every frame
//   fcs_state_e     : inserter FSM states
//   fcs_byte()      : selects one transmitted FCS byte from the CRC register
// -----------------------------------------------------------------------------
package eth_pkg;

   localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
   localparam int unsigned MIN_FRAME_BYTES = 60;
   localparam int unsigned FCS_BYTES       = 4;

   typedef enum logic [1:0] {
      ST_DATA = 2'd0,   // pass input bytes through
      ST_PAD  = 2'd1,   // emit 0x00 until the minimum length is reached
      ST_FCS  = 2'd2    // emit the four FCS bytes
   } fcs_state_e;

   // The CRC register shifts MSB-first, but Ethernet transmits the FCS
   // bit-reflected and inverted, least significant byte first. Reflecting the
   // whole register once makes byte k a plain 8-bit slice.
   function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                           input logic [1:0]  idx);
      logic [31:0] refl;
      for (int j = 0; j < 32; j++) begin
         refl[j] = ~crc[31-j];
      end
      return refl[8*idx +: 8];
   endfunction

endpackage

// File: rtl/calculate_crc.sv
// -----------------------------------------------------------------------------
// calculate_crc
// Purely combinational CRC step: folds one DATA_W-bit word into a CRC_W-bit
// register. Data bit 0 is consumed first; the register shifts towards its MSB
// and the polynomial is applied whenever the feedback bit is set.
//   crc      : current CRC register value
//   data     : data word to fold in
//   crc_next : CRC register value after the word
// -----------------------------------------------------------------------------
module calculate_crc #(
   parameter int                DATA_W = 8,
   parameter int                CRC_W  = 32,
   parameter logic [CRC_W-1:0]  POLY   = CRC_W'(eth_pkg::CRC_POLY)
) (
   input  logic [CRC_W-1:0]  crc,
   input  logic [DATA_W-1:0] data,
   output logic [CRC_W-1:0]  crc_next
);

   always_comb begin
      // NOTE: blocking assignments are deliberate here -- each loop iteration
      // must see the previous bit's result, and the unconditional copy first
      // gives crc_next a value on every path so no latch is inferred.
      crc_next = crc;
      for (int i = 0; i < DATA_W; i++) begin
         if (crc_next[CRC_W-1] ^ data[i]) begin
            crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ POLY;
         end else begin
            crc_next = {crc_next[CRC_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/eth_fcs_inserter.sv
// -----------------------------------------------------------------------------
// eth_fcs_inserter
// Byte-stream Ethernet FCS inserter. Frames arrive without FCS; the block
// optionally pads short frames with 0x00 up to MIN_FRAME_BYTES and appends the
// CRC-32 frame check sequence. Output is a single registered slot, so an
// accepted input byte appears on the output one cycle later.
//
// Parameters
//   DATA_W   : datapath width, only 8 is supported
//   PAD_EN   : 1 = pad short frames to MIN_FRAME_BYTES, 0 = no padding
//   CRC_POLY : CRC-32 generator polynomial
// Ports
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   s_data_i  in   frame byte (destination MAC first, no FCS)
//   s_valid_i in   s_data_i / s_last_i valid
//   s_last_i  in   final payload byte of the frame
//   s_ready_o out  input byte is accepted this cycle
//   m_data_o  out  frame byte including pad and FCS
//   m_valid_o out  m_data_o / m_last_o valid
//   m_last_o  out  final FCS byte of the frame
//   m_ready_i in   downstream accepts the output byte this cycle
// -----------------------------------------------------------------------------
module eth_fcs_inserter #(
   parameter int          DATA_W   = 8,
   parameter bit          PAD_EN   = 1'b1,
   parameter logic [31:0] CRC_POLY = eth_pkg::CRC_POLY
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_valid_o,
   output logic              m_last_o,
   input  logic              m_ready_i
);

   import eth_pkg::*;

   localparam logic [5:0] CNT_MAX  = 6'(MIN_FRAME_BYTES);
   localparam logic [1:0] FCS_LAST = 2'(FCS_BYTES - 1);

   fcs_state_e        state;
   logic [5:0]        byte_cnt;    // DATA/PAD bytes loaded this frame, saturating
   logic [5:0]        cnt_inc;     // byte_cnt after counting the byte being loaded
   logic [1:0]        fcs_idx;     // next FCS byte to emit
   logic [31:0]       crc_q;
   logic [31:0]       crc_next;
   logic [DATA_W-1:0] crc_din;
   logic              run_q;       // holds input off until the first edge after reset
   logic              slot_free;
   logic              load_data;

   // The output register can take a new byte when it is empty or being drained.
   assign slot_free = !m_valid_o || m_ready_i;
   assign s_ready_o = run_q && (state == ST_DATA) && slot_free;
   assign load_data = s_ready_o && s_valid_i;

   assign cnt_inc = (byte_cnt == CNT_MAX) ? CNT_MAX : byte_cnt + 6'd1;

   // Pad bytes are zeros and must enter the CRC exactly like payload bytes.
   assign crc_din = (state == ST_PAD) ? '0 : s_data_i;

   calculate_crc #(
      .DATA_W (DATA_W),
      .CRC_W  (32),
      .POLY   (CRC_POLY)
   ) u_crc (
      .crc      (crc_q),
      .data     (crc_din),
      .crc_next (crc_next)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_DATA;
         byte_cnt  <= '0;
         fcs_idx   <= '0;
         crc_q     <= CRC_INIT;
         m_data_o  <= '0;
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         run_q <= 1'b1;
         // Nothing in the output slot changes while a byte is stalled in it.
         if (slot_free) begin
            case (state)
               ST_DATA: begin
                  m_valid_o <= load_data;
                  m_last_o  <= 1'b0;
                  if (load_data) begin
                     m_data_o <= s_data_i;
                     crc_q    <= crc_next;
                     byte_cnt <= cnt_inc;
                     if (s_last_i) begin
                        if (PAD_EN && (cnt_inc < CNT_MAX)) begin
                           state <= ST_PAD;
                        end else begin
                           state <= ST_FCS;
                        end
                     end
                  end
               end

               ST_PAD: begin
                  m_data_o  <= '0;
                  m_valid_o <= 1'b1;
                  m_last_o  <= 1'b0;
                  crc_q     <= crc_next;
                  byte_cnt  <= cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state <= ST_FCS;
                  end
               end

               ST_FCS: begin
                  // crc_q is not updated here, so all four bytes come from the
                  // value frozen when the frame body ended.
                  m_data_o  <= fcs_byte(crc_q, fcs_idx);
                  m_valid_o <= 1'b1;
                  m_last_o  <= (fcs_idx == FCS_LAST);
                  if (fcs_idx == FCS_LAST) begin
                     state    <= ST_DATA;
                     byte_cnt <= '0;
                     fcs_idx  <= '0;
                     crc_q    <= CRC_INIT;
                  end else begin
                     fcs_idx <= fcs_idx + 2'd1;
                  end
               end

               default: begin
                  state     <= ST_DATA;
                  m_valid_o <= 1'b0;
                  m_last_o  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// -----------------------------------------------------------------------------
// tb_eth_fcs_inserter
// Two inserter instances (PAD_EN=1 and PAD_EN=0) share the stimulus; sel_pad
// chooses which one is driven and observed. Expected output comes from a
// frame-level model: pad the body, run a reflected byte-wise CRC-32, append
// the inverted CRC little-endian.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_fcs_inserter;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       m_ready;
   logic       sel_pad;

   logic       a_s_ready, a_m_valid, a_m_last;
   logic [7:0] a_m_data;
   logic       b_s_ready, b_m_valid, b_m_last;
   logic [7:0] b_m_data;

   logic       sel_s_ready, sel_m_valid, sel_m_last;
   logic [7:0] sel_m_data;

   always #5 clk = ~clk;

   eth_fcs_inserter #(.DATA_W(8), .PAD_EN(1'b1), .CRC_POLY(32'h04C11DB7)) dut_pad (
      .clk_i     (clk),
      .rst_i     (rst),
      .s_data_i  (s_data),
      .s_valid_i (s_valid && sel_pad),
      .s_last_i  (s_last),
      .s_ready_o (a_s_ready),
      .m_data_o  (a_m_data),
      .m_valid_o (a_m_valid),
      .m_last_o  (a_m_last),
      .m_ready_i (m_ready)
   );

   eth_fcs_inserter #(.DATA_W(8), .PAD_EN(1'b0), .CRC_POLY(32'h04C11DB7)) dut_nopad (
      .clk_i     (clk),
      .rst_i     (rst),
      .s_data_i  (s_data),
      .s_valid_i (s_valid && !sel_pad),
      .s_last_i  (s_last),
      .s_ready_o (b_s_ready),
      .m_data_o  (b_m_data),
      .m_valid_o (b_m_valid),
      .m_last_o  (b_m_last),
      .m_ready_i (m_ready)
   );

   assign sel_s_ready = sel_pad ? a_s_ready : b_s_ready;
   assign sel_m_valid = sel_pad ? a_m_valid : b_m_valid;
   assign sel_m_last  = sel_pad ? a_m_last  : b_m_last;
   assign sel_m_data  = sel_pad ? a_m_data  : b_m_data;

   int         vectors = 0;
   int         errors  = 0;
   int         cycle   = 0;
   bit         stall_mode = 1'b0;
   bit         gap_mode   = 1'b0;
   beat_t      exp_q[$];
   logic [7:0] cap_q[$];
   int         cap_cyc[$];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference CRC-32: reflected polynomial, LSB-first, byte at a time.
   function automatic logic [31:0] crc32_ref(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (q[j]) begin
         c = c ^ {24'h0, q[j]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic expect_frame(input logic [7:0] fr[$], input bit pad);
      logic [7:0]  body[$];
      logic [31:0] fcs;
      beat_t       b;
      body = fr;
      if (pad) begin
         while (body.size() < 60) body.push_back(8'h00);
      end
      fcs = crc32_ref(body);
      foreach (body[j]) begin
         b.data = body[j];
         b.last = 1'b0;
         exp_q.push_back(b);
      end
      for (int k = 0; k < 4; k++) begin
         b.data = fcs[8*k +: 8];
         b.last = (k == 3);
         exp_q.push_back(b);
      end
   endtask

   // Called and returns at posedge+1.
   task automatic send_frame(input logic [7:0] fr[$]);
      int   i = 0;
      int   guard = 0;
      logic took;
      while (i < fr.size()) begin
         if (gap_mode && ($urandom_range(0, 2) == 0)) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = fr[i];
            s_last  = (i == fr.size() - 1);
         end
         @(negedge clk);
         took = s_valid && sel_s_ready;
         @(posedge clk);
         #1;
         if (took) i++;
         guard++;
         if (guard > 3000) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", i, fr.size());
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 3000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         errors++;
         $display("FAIL drain_timeout: %0d expected bytes never appeared", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Compare process: checks every transferred byte against the model and
   // checks that a stalled byte holds still.
   initial begin : compare
      logic       pv, pl, pr;
      logic [7:0] pd;
      beat_t      e;
      pv = 1'b0; pl = 1'b0; pr = 1'b1; pd = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !pr) begin
            check("hold_valid", 32'(sel_m_valid), 32'd1);
            check("hold_data",  32'(sel_m_data),  32'(pd));
            check("hold_last",  32'(sel_m_last),  32'(pl));
         end
         if (sel_m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_beat: got data %h last %b, expected no output",
                        sel_m_data, sel_m_last);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 32'(sel_m_data), 32'(e.data));
               check("beat_last", 32'(sel_m_last), 32'(e.last));
            end
            cap_q.push_back(sel_m_data);
            cap_cyc.push_back(cycle);
         end
         pv = sel_m_valid;
         pd = sel_m_data;
         pl = sel_m_last;
         pr = m_ready;
      end
   end

   initial begin : ready_drv
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = stall_mode ? ~m_ready : 1'b1;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [7:0] f123[$];
      logic [7:0] f[$];
      logic [7:0] ref_q[$];
      int         nz;
      int         diff;

      f123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel_pad = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 32'(a_m_valid), 32'd0);
      check("rst_m_last",  32'(a_m_last),  32'd0);
      check("rst_m_data",  32'(a_m_data),  32'h00);
      check("rst_s_ready", 32'(a_s_ready), 32'd0);
      check("rst_s_ready_nopad", 32'(b_s_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release_s_ready_before_edge", 32'(a_s_ready), 32'd0);
      @(posedge clk);
      #1;
      check("release_s_ready_after_edge", 32'(a_s_ready), 32'd1);

      // Pin the model to the published CRC-32 check value.
      check("model_crc_check", crc32_ref(f123), 32'hCBF4_3926);

      // "123456789", no padding
      sel_pad = 1'b0;
      cap_q.delete(); cap_cyc.delete();
      expect_frame(f123, 1'b0);
      send_frame(f123);
      drain();
      check("ascii_len", 32'(cap_q.size()), 32'd13);
      if (cap_q.size() == 13) begin
         check("ascii_first", 32'(cap_q[0]),  32'h31);
         check("ascii_fcs0",  32'(cap_q[9]),  32'h26);
         check("ascii_fcs1",  32'(cap_q[10]), 32'h39);
         check("ascii_fcs2",  32'(cap_q[11]), 32'hF4);
         check("ascii_fcs3",  32'(cap_q[12]), 32'hCB);
      end

      // 1-byte frame padded to 60
      sel_pad = 1'b1;
      cap_q.delete(); cap_cyc.delete();
      f = '{8'h00};
      expect_frame(f, 1'b1);
      send_frame(f);
      drain();
      check("pad1_len", 32'(cap_q.size()), 32'd64);
      nz = 0;
      for (int j = 1; j < 60 && j < cap_q.size(); j++) if (cap_q[j] != 8'h00) nz++;
      check("pad1_zero_bytes", 32'(nz), 32'd0);

      // 60-byte frame: no pad
      cap_q.delete(); cap_cyc.delete();
      f.delete();
      for (int j = 0; j < 60; j++) f.push_back(8'(j) ^ 8'h5A);
      expect_frame(f, 1'b1);
      send_frame(f);
      drain();
      check("len60_len", 32'(cap_q.size()), 32'd64);

      // 64-byte frame, free-flowing, then stalled with input gaps
      cap_q.delete(); cap_cyc.delete();
      f.delete();
      for (int j = 0; j < 64; j++) f.push_back(8'(j * 7 + 3));
      expect_frame(f, 1'b1);
      send_frame(f);
      drain();
      ref_q = cap_q;
      check("len64_len", 32'(ref_q.size()), 32'd68);

      cap_q.delete(); cap_cyc.delete();
      stall_mode = 1'b1;
      gap_mode   = 1'b1;
      expect_frame(f, 1'b1);
      send_frame(f);
      drain();
      stall_mode = 1'b0;
      gap_mode   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("stall_len", 32'(cap_q.size()), 32'(ref_q.size()));
      diff = 0;
      for (int j = 0; j < cap_q.size() && j < ref_q.size(); j++) if (cap_q[j] != ref_q[j]) diff++;
      check("stall_stream_equal", 32'(diff), 32'd0);

      // Back-to-back frames, CRC reinitialisation, no idle cycles
      sel_pad = 1'b0;
      cap_q.delete(); cap_cyc.delete();
      expect_frame(f123, 1'b0);
      expect_frame(f123, 1'b0);
      send_frame(f123);
      send_frame(f123);
      drain();
      check("b2b_len", 32'(cap_q.size()), 32'd26);
      if (cap_q.size() == 26) begin
         check("b2b_f1_fcs0", 32'(cap_q[9]),  32'h26);
         check("b2b_f1_fcs3", 32'(cap_q[12]), 32'hCB);
         check("b2b_f2_fcs0", 32'(cap_q[22]), 32'h26);
         check("b2b_f2_fcs1", 32'(cap_q[23]), 32'h39);
         check("b2b_f2_fcs2", 32'(cap_q[24]), 32'hF4);
         check("b2b_f2_fcs3", 32'(cap_q[25]), 32'hCB);
         check("b2b_contiguous", 32'(cap_cyc[25] - cap_cyc[0]), 32'd25);
      end

      // Reset while FCS byte 2 is presented
      cap_q.delete(); cap_cyc.delete();
      expect_frame(f123, 1'b0);
      send_frame(f123);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_presented_fcs2", 32'(sel_m_data), 32'hF4);
      rst = 1'b1;
      #1;
      check("midrst_m_valid", 32'(sel_m_valid), 32'd0);
      check("midrst_m_last",  32'(sel_m_last),  32'd0);
      check("midrst_m_data",  32'(sel_m_data),  32'h00);
      check("midrst_s_ready", 32'(sel_s_ready), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_release_ready", 32'(sel_s_ready), 32'd1);
      check("midrst_release_valid", 32'(sel_m_valid), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      cap_q.delete(); cap_cyc.delete();
      expect_frame(f123, 1'b0);
      send_frame(f123);
      drain();
      check("postrst_len", 32'(cap_q.size()), 32'd13);
      if (cap_q.size() == 13) begin
         check("postrst_fcs0", 32'(cap_q[9]),  32'h26);
         check("postrst_fcs3", 32'(cap_q[12]), 32'hCB);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/eth_fcs_inserter.md
ETH_FCS_INSERTER -- requirements
Module: eth_fcs_inserter

Interface
REQ-001 Parameter DATA_W, default 8, byte-wide datapath width; only 8 is supported.
REQ-002 Parameter PAD_EN, default 1; 1 = pad short frames to MIN_FRAME_BYTES before FCS, 0 = no padding.
REQ-003 Parameter CRC_POLY, default 32'h04C11DB7, Ethernet CRC-32 polynomial.
REQ-004 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 s_data_i  input  8  frame byte in, destination MAC first, no FCS.
REQ-007 s_valid_i  input  1  s_data_i/s_last_i valid.
REQ-008 s_last_i  input  1  marks the final payload byte of a frame.
REQ-009 s_ready_o  output  1  block accepts the input byte this cycle.
REQ-010 m_data_o  output  8  frame byte out, including pad and FCS.
REQ-011 m_valid_o  output  1  m_data_o/m_last_o valid.
REQ-012 m_last_o  output  1  marks FCS byte 3, the final byte of the frame.
REQ-013 m_ready_i  input  1  downstream accepts the output byte this cycle.

Function
REQ-014 A transfer SHALL occur on a side when valid && ready are both high at the rising edge.
REQ-015 The FSM SHALL have three states: DATA (pass input), PAD (emit 0x00), FCS (emit 4 FCS bytes).
REQ-016 Output SHALL be registered: m_valid_o/m_data_o/m_last_o update only when !m_valid_o || m_ready_i (output slot free).
REQ-017 s_ready_o SHALL be high only in DATA with the output slot free, so input-to-output latency is 1 cycle.
REQ-018 m_data_o, m_valid_o and m_last_o SHALL hold stable while m_valid_o && !m_ready_i.
REQ-019 The CRC register SHALL start each frame at 32'hFFFFFFFF and update through calculate_crc (data bit 0 first, MSB-shift register) on every DATA and PAD byte loaded into the output slot.
REQ-020 A byte counter SHALL count loaded DATA/PAD bytes per frame and saturate at MIN_FRAME_BYTES (60).
REQ-021 On accepted s_last_i: if PAD_EN=1 and count incl. this byte < 60, go to PAD; otherwise go to FCS.
REQ-022 PAD SHALL emit 0x00 bytes, one per free output slot, until the count reaches 60, then go to FCS.
REQ-023 FCS SHALL emit bytes k=0..3 with bit i of byte k = ~crc[31-8k-i] (reflected, inverted, LSB byte first), using the CRC frozen at FCS entry.
REQ-024 m_last_o SHALL be high only with FCS byte 3; when that byte is loaded, go to DATA, clear the counter and reload the CRC to 32'hFFFFFFFF.
REQ-025 Back-to-back frames SHALL be supported: the first byte of the next frame may be accepted in the cycle after FCS byte 3 is loaded, with no idle insertion.
REQ-026 A 1-byte frame with s_last_i SHALL be legal; frames with PAD_EN=0 and zero bytes are not defined.
REQ-027 Frames at or above 60 bytes SHALL receive no padding; there is no maximum-length check.

Reset
REQ-028 rst_i high SHALL immediately force state DATA, counter 0, CRC 32'hFFFFFFFF, m_valid_o 0, m_last_o 0, m_data_o 8'h00, s_ready_o 0.
REQ-029 Reset mid-frame SHALL abandon the frame; no partial FCS is emitted after release.
REQ-030 s_ready_o SHALL go high on the first edge after rst_i is released.

Structure
REQ-031 Package eth_pkg SHALL hold CRC_POLY, CRC_INIT (32'hFFFFFFFF), MIN_FRAME_BYTES (60), FCS_BYTES (4) and the FSM state enum.
REQ-032 The block SHALL instantiate calculate_crc (DATA_W=8, CRC_W=32) as its one sub-module; the CRC logic is not duplicated.

Verification
REQ-033 PAD_EN=0, ASCII "123456789", m_ready_i=1 -> 13 bytes out, last four 26 39 F4 CB, m_last_o on byte 13 only.
REQ-034 PAD_EN=1, 1-byte frame 0x00 -> 64 bytes out, bytes 2..60 = 0x00, FCS equals the golden CRC-32 model, m_last_o on byte 64.
REQ-035 PAD_EN=1, 60-byte frame -> exactly 64 bytes out, no pad inserted.
REQ-036 64-byte frame with m_ready_i toggling 1/0 each cycle and random s_valid_i gaps -> byte stream identical to the no-stall run, outputs stable while stalled.
REQ-037 Two back-to-back 9-byte "123456789" frames, PAD_EN=0 -> both end in 26 39 F4 CB, proving CRC reinitialisation.
REQ-038 rst_i pulsed while FCS byte 2 is presented -> m_valid_o 0 at once; the next frame after release produces the correct FCS.
